// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: buffers {pc, seq, cycle} records of retired instructions
// in a small FIFO and monitors PC-chain continuity, record loss and commit starvation.
module commit_trace_buffer #(
    parameter int          DEPTH           = 8,
    parameter int          WATCHDOG_CYCLES = 1024,
    parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit,
    input  logic [31:0]            commit_pc,
    input  logic [31:0]            commit_pre_pc,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic [31:0]            trace_seq,
    output logic [31:0]            trace_cycle,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            instret,
    output logic                   mismatch,
    output logic [31:0]            mismatch_pc,
    output logic [31:0]            mismatch_exp,
    output logic                   overflow,
    output logic                   hang
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
    localparam int REC_W = 96;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(WATCHDOG_CYCLES);

    // Record layout: {pc, seq, cycle}
    logic [REC_W-1:0] recMem [DEPTH];
    logic [REC_W-1:0] recIn;
    logic [REC_W-1:0] headReg;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdNext;
    logic [CNT_W-1:0] countReg;

    logic [31:0]      instretReg;
    logic [31:0]      cycleReg;
    logic [31:0]      expectPc;
    logic [WD_W-1:0]  wdCount;
    logic [WD_W-1:0]  wdNext;

    logic             pop;
    logic             push;
    logic             loadFromInput;
    logic             loadFromMem;

    assign trace_valid = (countReg != CNT_ZERO);
    assign pop         = trace_valid & trace_ready;
    assign push        = commit & ((countReg != CNT_FULL) | pop);
    assign rdNext      = rdPtr + PTR_ONE;
    assign recIn       = {commit_pc, instretReg, cycleReg};

    // The head register takes the incoming record when it becomes the only entry,
    // otherwise it advances to the next stored entry on a pop.
    assign loadFromInput = push & ((countReg == CNT_ZERO) | ((countReg == CNT_ONE) & pop));
    assign loadFromMem   = pop & (countReg > CNT_ONE);

    always_comb begin
        wdNext = wdCount;
        if (commit) begin
            wdNext = '0;
        end else if (wdCount != WD_MAX) begin
            wdNext = wdCount + WD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            recMem[wrPtr] <= recIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            countReg     <= '0;
            headReg      <= '0;
            instretReg   <= '0;
            cycleReg     <= '0;
            expectPc     <= RESET_PC;
            wdCount      <= '0;
            mismatch     <= 1'b0;
            mismatch_pc  <= '0;
            mismatch_exp <= '0;
            overflow     <= 1'b0;
            hang         <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdNext;
            end
            case ({push, pop})
                2'b10:   countReg <= countReg + CNT_ONE;
                2'b01:   countReg <= countReg - CNT_ONE;
                default: countReg <= countReg;
            endcase

            if (loadFromInput) begin
                headReg <= recIn;
            end else if (loadFromMem) begin
                headReg <= recMem[rdNext];
            end

            cycleReg <= cycleReg + 32'd1;

            if (commit) begin
                instretReg <= instretReg + 32'd1;
                expectPc   <= commit_pre_pc;
                if (!push) begin
                    overflow <= 1'b1;
                end
                // Only the first break in the PC chain is latched.
                if ((commit_pc != expectPc) && !mismatch) begin
                    mismatch     <= 1'b1;
                    mismatch_pc  <= commit_pc;
                    mismatch_exp <= expectPc;
                end
            end

            wdCount <= wdNext;
            if (wdNext == WD_MAX) begin
                hang <= 1'b1;
            end
        end
    end

    assign trace_pc    = headReg[95:64];
    assign trace_seq   = headReg[63:32];
    assign trace_cycle = headReg[31:0];
    assign fifo_count  = countReg;
    assign instret     = instretReg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios plus random retire/drain traffic,
// checked against a queue-based reference model of the trace stream and monitors.
module tb_commit_trace_buffer;

    localparam int          DEPTH = 8;
    localparam int          WD    = 16;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_pre_pc = '0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_seq, trace_cycle;
    logic [3:0]  fifo_count;
    logic [31:0] instret;
    logic        mismatch;
    logic [31:0] mismatch_pc, mismatch_exp;
    logic        overflow, hang;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] seq;
        logic [31:0] cyc;
    } rec_t;

    rec_t        q[$];
    logic [31:0] mInstret, mCycle, mExpPc, mMmPc, mMmExp;
    bit          mMm, mOvf, mHang;
    int          mIdle;

    commit_trace_buffer #(
        .DEPTH(DEPTH),
        .WATCHDOG_CYCLES(WD),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .commit(commit),
        .commit_pc(commit_pc),
        .commit_pre_pc(commit_pre_pc),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_pc(trace_pc),
        .trace_seq(trace_seq),
        .trace_cycle(trace_cycle),
        .fifo_count(fifo_count),
        .instret(instret),
        .mismatch(mismatch),
        .mismatch_pc(mismatch_pc),
        .mismatch_exp(mismatch_exp),
        .overflow(overflow),
        .hang(hang)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mInstret = 0;
        mCycle   = 0;
        mExpPc   = RPC;
        mMm      = 0;
        mMmPc    = 0;
        mMmExp   = 0;
        mOvf     = 0;
        mHang    = 0;
        mIdle    = 0;
    endtask

    task automatic checkAll();
        check("trace_valid", {31'd0, trace_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        check("fifo_count", {28'd0, fifo_count}, q.size());
        check("instret", instret, mInstret);
        check("mismatch", {31'd0, mismatch}, {31'd0, mMm});
        check("mismatch_pc", mismatch_pc, mMmPc);
        check("mismatch_exp", mismatch_exp, mMmExp);
        check("overflow", {31'd0, overflow}, {31'd0, mOvf});
        check("hang", {31'd0, hang}, {31'd0, mHang});
        if (q.size() > 0) begin
            check("trace_pc", trace_pc, q[0].pc);
            check("trace_seq", trace_seq, q[0].seq);
            check("trace_cycle", trace_cycle, q[0].cyc);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit c, input logic [31:0] pc, input logic [31:0] pre, input bit rdy);
        bit popNow;
        int held;
        commit        = c;
        commit_pc     = pc;
        commit_pre_pc = pre;
        trace_ready   = rdy;
        held   = q.size();
        popNow = (held > 0) && rdy;
        if (popNow) void'(q.pop_front());
        if (c) begin
            if (held < DEPTH || popNow) q.push_back('{pc: pc, seq: mInstret, cyc: mCycle});
            else mOvf = 1;
            if (pc != mExpPc && !mMm) begin
                mMm    = 1;
                mMmPc  = pc;
                mMmExp = mExpPc;
            end
            mExpPc   = pre;
            mInstret = mInstret + 1;
            mIdle    = 0;
        end else if (mIdle < WD) begin
            mIdle++;
        end
        if (mIdle >= WD) mHang = 1;
        mCycle = mCycle + 1;
        @(posedge clk);
        #1;
        $display("step t=%0t commit=%0b pc=%h ready=%0b count=%0d seq=%0d", $time, c, pc, rdy,
                 fifo_count, trace_seq);
        checkAll();
    endtask

    task automatic chain(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1, mExpPc, mExpPc + 32'd4, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, $urandom, $urandom, rdy);
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        check("rst_valid", {31'd0, trace_valid}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_trace_pc", trace_pc, 32'd0);
        check("rst_trace_seq", trace_seq, 32'd0);
        check("rst_trace_cycle", trace_cycle, 32'd0);
        check("rst_flags", {29'd0, mismatch, overflow, hang}, 32'd0);

        // Watchdog: a 15-cycle gap must not trip it
        idle(15, 1);
        check("wd_gap15", {31'd0, hang}, 32'd0);

        // Sequential retire
        step(1, 32'h8000_0000, 32'h8000_0004, 1);
        check("seq0_valid", {31'd0, trace_valid}, 32'd1);
        check("seq0_seq", trace_seq, 32'd0);
        step(1, 32'h8000_0004, 32'h8000_0008, 1);
        check("seq1_seq", trace_seq, 32'd1);
        step(1, 32'h8000_0008, 32'h8000_000C, 1);
        check("seq2_seq", trace_seq, 32'd2);
        check("seq_instret", instret, 32'd3);
        check("seq_mismatch", {31'd0, mismatch}, 32'd0);
        idle(1, 1);

        // Watchdog: 16 idle cycles trip it, a later commit keeps it set
        idle(16, 1);
        check("wd_hang", {31'd0, hang}, 32'd1);
        chain(1, 1);
        check("wd_sticky", {31'd0, hang}, 32'd1);
        idle(1, 1);

        // Full FIFO with simultaneous pop, then overflow, then drain
        chain(8, 0);
        check("full_count", {28'd0, fifo_count}, 32'd8);
        chain(1, 1);
        check("fullpop_count", {28'd0, fifo_count}, 32'd8);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        chain(2, 0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        idle(8, 1);
        check("drain_empty", {31'd0, trace_valid}, 32'd0);

        // Jump chain and first-mismatch latching
        step(1, mExpPc, 32'h8000_0010, 1);
        step(1, 32'h8000_0010, 32'h8000_0100, 1);
        step(1, 32'h8000_0014, 32'h8000_0018, 1);
        check("jump_mm", {31'd0, mismatch}, 32'd1);
        check("jump_mm_pc", mismatch_pc, 32'h8000_0014);
        check("jump_mm_exp", mismatch_exp, 32'h8000_0100);
        step(1, 32'h8000_0200, 32'h8000_0204, 1);
        check("jump_keep_pc", mismatch_pc, 32'h8000_0014);
        check("jump_keep_exp", mismatch_exp, 32'h8000_0100);
        idle(2, 1);

        // Asynchronous reset with 5 records buffered, then a commit held under reset
        chain(5, 0);
        chain(1, 1);
        check("pre_rst_count", {28'd0, fifo_count}, 32'd5);
        #1;
        rst = 1;
        #1;
        check("arst_valid", {31'd0, trace_valid}, 32'd0);
        check("arst_count", {28'd0, fifo_count}, 32'd0);
        check("arst_instret", instret, 32'd0);
        check("arst_flags", {29'd0, mismatch, overflow, hang}, 32'd0);
        commit    = 1;
        commit_pc = RPC;
        @(posedge clk);
        #1;
        check("rst_commit_instret", instret, 32'd0);
        check("rst_commit_count", {28'd0, fifo_count}, 32'd0);
        #1;
        rst = 0;
        modelReset();
        step(1, RPC, RPC + 32'd4, 1);
        check("post_rst_seq", trace_seq, 32'd0);
        check("post_rst_cycle", trace_cycle, 32'd0);
        check("post_rst_mm", {31'd0, mismatch}, 32'd0);

        // Random retire/drain traffic
        for (int i = 0; i < 400; i++) begin
            bit          c, rdy;
            logic [31:0] pc, pre;
            c   = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 50);
            pc  = ($urandom_range(0, 19) == 0) ? ($urandom & 32'hFFFF_FFFC) : mExpPc;
            pre = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
            if (!c) pc = $urandom;
            step(c, pc, pre, rdy);
        end
        idle(DEPTH + 1, 1);
        check("final_empty", {31'd0, trace_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
